serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial adder/subtractor that feeds the single-bit full adder cell one operand bit pair per clock and consumes its sum and carry.
- The block holds a carry flip-flop between bit slices and shifts results back into a register.
- Gives the ALU a low-area alternative datapath: one fulladder instance plus registers instead of a WIDTH-bit ripple chain.
- Sits between the operand/opcode decode stage (upstream) and the result/flag writeback (downstream).

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request a new operation; accepted only on an edge where busy=0.
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result and flags were updated on the preceding edge.
- result  output  WIDTH  last completed sum/difference.
- carryout  output  1  carry out of MSB slice; for subtraction 1 = no borrow.
- overflow  output  1  signed overflow = (carry into MSB) XOR (carry out of MSB).
- zero  output  1  result == 0.

Behaviour:
- Reset (rst_n=0 at an edge, highest priority): state=IDLE, busy=0, done=0, result=0, carryout=0, overflow=0, zero=0, bit counter=0, carry FF=0.
- Reset mid-operation abandons the operation and does not pulse done.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Acceptance: at an edge where busy=0 (IDLE or DONE) and start=1:
  - latch A into shift register SA;
  - latch B into SB, or ~b when op_sub=1;
  - carry FF <= op_sub;
  - counter <= 0;
  - go to RUN.
- RUN, each edge:
  - The fulladder is fed (SA[0], SB[0], carry FF).
  - The sum bit shifts into the MSB of the working register W (right shift).
  - SA and SB shift right; carry FF <= fulladder carry; counter++.
  - On the edge where counter == WIDTH-1, the carry into that slice is captured as cin_msb.
- Completion: the edge processing bit WIDTH-1 also:
  - writes result <= final W;
  - writes carryout <= final carry;
  - writes overflow <= cin_msb XOR final carry;
  - writes zero <= (final W == 0);
  - moves to DONE.
- Latency: start accepted at edge E0 -> bits 0..WIDTH-1 processed at edges E1..E_WIDTH -> done=1 between E_WIDTH and E_WIDTH+1. One op per WIDTH+1 cycles; back-to-back is possible by asserting start during DONE.
- DONE -> IDLE on the next edge if start=0, else -> RUN. done never stays high more than 1 cycle unless a new op completes.
- result and flags hold their values throughout RUN and IDLE; they change only on a completion edge or reset.
- start while busy=1 is ignored (no queueing). Changes to a/b/op_sub after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH; subtraction is two's complement (A + ~B + 1).
- The adder slice is an instance of the team's fulladder cell; no wide adders in this block.

Test Plan:
- WIDTH=8, reset then a=0x7F, b=0x01, op_sub=0, start pulse -> busy for 8 cycles, done pulse at cycle 9; result=0x80, carryout=0, overflow=1, zero=0.
- a=0x05, b=0x05, op_sub=1 -> result=0x00, carryout=1, overflow=0, zero=1; a=0x03, b=0x05, op_sub=1 -> result=0xFE, carryout=0, overflow=0, zero=0.
- a=0xFF, b=0x01, op_sub=0 -> result=0x00, carryout=1, overflow=0, zero=1; a=0x80, b=0x01, op_sub=1 -> result=0x7F, overflow=1, carryout=1.
- Start 0x10+0x20; at cycle 3 assert start with a=0xAA, b=0x55 and change a/b -> second start ignored; result=0x30 at done. Then assert start during the done cycle with 0x01+0x01 -> busy again next cycle, result=0x02 after 8 more cycles.
- Deassert rst_n for one edge at RUN cycle 4 -> busy=0, done=0, result=0, flags=0 next cycle; no done pulse follows. A subsequent start completes normally.
- Reset then idle 20 cycles with start=0 -> busy=0, done=0, outputs stable at 0 throughout.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Handshake and result bus between the operand decode stage and the bit-serial add/sub unit.
interface serial_addsub_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op_sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             carryout;
   logic             overflow;
   logic             zero;

   modport master (
      output start, op_sub, a, b,
      input  busy, done, result, carryout, overflow, zero
   );

   modport slave (
      input  start, op_sub, a, b,
      output busy, done, result, carryout, overflow, zero
   );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one fulladder slice per clock, WIDTH+1 cycles per op.
// Start is only taken while not busy; requests during RUN are dropped, not queued.

module fulladder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   serial_addsub_if.slave  bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] w;
   logic             cf;
   logic [CW-1:0]    cnt;

   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             ovf_q;
   logic             zero_q;

   logic             fa_sum;
   logic             fa_cout;
   logic [WIDTH-1:0] w_next;
   logic             last;

   fulladder u_fa (
      .a    (sa[0]),
      .b    (sb[0]),
      .cin  (cf),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign w_next = {fa_sum, w[WIDTH-1:1]};
   assign last   = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         sa       <= '0;
         sb       <= '0;
         w        <= '0;
         cf       <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  sa     <= bus.a;
                  // subtraction is A + ~B + 1: the +1 enters as the initial carry
                  sb     <= bus.op_sub ? ~bus.b : bus.b;
                  cf     <= bus.op_sub;
                  cnt    <= '0;
                  w      <= '0;
                  state  <= RUN;
                  busy_q <= 1'b1;
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               w   <= w_next;
               cf  <= fa_cout;
               cnt <= cnt + CW'(1);
               if (last) begin
                  // cf still holds the carry into the MSB slice on this edge
                  result_q <= w_next;
                  carry_q  <= fa_cout;
                  ovf_q    <= cf ^ fa_cout;
                  zero_q   <= (w_next == '0);
                  state    <= DONE;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.carryout = carry_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Randomized and directed bench for serial_addsub (WIDTH=8) against a transaction-level model.
module tb_serial_addsub;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   logic chk_en;
   int   n_chk;
   int   n_fail;

   serial_addsub_if #(.WIDTH(W)) bus ();

   serial_addsub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: computes each op's outcome arithmetically at acceptance, publishes it WIDTH edges later.
   logic         m_busy, m_done, m_c, m_v, m_z;
   logic [W-1:0] m_res;
   logic [W-1:0] p_res;
   logic         p_c, p_v, p_z;
   int           m_left;

   task automatic compute(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          output logic [W-1:0] r, output logic c, output logic v, output logic z);
      int ua, ub, ur, sa, sbv, sr;
      ua  = int'(a);
      ub  = int'(b);
      sa  = (ua >= 128) ? ua - 256 : ua;
      sbv = (ub >= 128) ? ub - 256 : ub;
      ur  = sub ? ua - ub : ua + ub;
      sr  = sub ? sa - sbv : sa + sbv;
      r   = W'(ur & 255);
      c   = sub ? (ua >= ub) : (ur > 255);
      v   = (sr > 127) || (sr < -128);
      z   = ((ur & 255) == 0);
   endtask

   initial begin
      m_busy = 0; m_done = 0; m_c = 0; m_v = 0; m_z = 0; m_res = '0; m_left = 0;
      p_res = '0; p_c = 0; p_v = 0; p_z = 0;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_res = '0; m_c = 0; m_v = 0; m_z = 0; m_left = 0;
      end else if (m_busy) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_busy = 0; m_done = 1;
            m_res = p_res; m_c = p_c; m_v = p_v; m_z = p_z;
         end
      end else if (bus.start) begin
         compute(bus.a, bus.b, bus.op_sub, p_res, p_c, p_v, p_z);
         m_left = W;
         m_busy = 1;
         m_done = 0;
      end else begin
         m_done = 0;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",     32'(bus.busy),     32'(m_busy));
         check("done",     32'(bus.done),     32'(m_done));
         check("result",   32'(bus.result),   32'(m_res));
         check("carryout", 32'(bus.carryout), 32'(m_c));
         check("overflow", 32'(bus.overflow), 32'(m_v));
         check("zero",     32'(bus.zero),     32'(m_z));
      end
   end

   // Drives start for exactly one edge from the current negedge.
   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      bus.a = a; bus.b = b; bus.op_sub = sub; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      @(negedge clk);
      drive_start(a, b, sub);
   endtask

   task automatic wait_done(input int from, output int cyc);
      cyc = from;
      while (!bus.done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 40) check("done_timeout", 32'(cyc), 32'(W + 1));
   endtask

   task automatic run_lit(input string nm, input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic [W-1:0] er, input logic ec, input logic ev, input logic ez);
      int cyc;
      start_op(a, b, sub);
      check({nm, "_busy"}, 32'(bus.busy), 32'd1);
      wait_done(1, cyc);
      check({nm, "_lat"}, 32'(cyc), 32'(W + 1));
      check({nm, "_res"}, 32'(bus.result), 32'(er));
      check({nm, "_c"},   32'(bus.carryout), 32'(ec));
      check({nm, "_v"},   32'(bus.overflow), 32'(ev));
      check({nm, "_z"},   32'(bus.zero), 32'(ez));
   endtask

   initial begin
      int cyc;
      bit b2b;
      logic [W-1:0] ra, rb;
      logic rs;
      n_chk = 0; n_fail = 0; chk_en = 0;
      rst_n = 1'b0;
      bus.start = 0; bus.op_sub = 0; bus.a = '0; bus.b = '0;
      repeat (2) @(negedge clk);
      chk_en = 1;
      rst_n = 1'b1;

      // idle after reset: everything held at zero
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_out", {26'd0, bus.busy, bus.done, bus.carryout, bus.overflow, bus.zero, 1'b0}, 32'd0);
         check("idle_res", 32'(bus.result), 32'd0);
      end

      run_lit("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
      run_lit("sub0505", 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
      run_lit("sub0305", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
      run_lit("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
      run_lit("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

      // start during RUN is ignored; operand changes after acceptance are ignored
      start_op(8'h10, 8'h20, 1'b0);
      @(negedge clk);
      drive_start(8'hAA, 8'h55, 1'b1);
      bus.a = 8'h77; bus.b = 8'h11;
      wait_done(3, cyc);
      check("ign_lat", 32'(cyc), 32'(W + 1));
      check("ign_res", 32'(bus.result), 32'h30);
      // back-to-back from the done cycle
      drive_start(8'h01, 8'h01, 1'b0);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      wait_done(1, cyc);
      check("b2b_lat", 32'(cyc), 32'(W + 1));
      check("b2b_res", 32'(bus.result), 32'h02);

      // reset mid-operation
      start_op(8'h33, 8'h44, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_res", 32'(bus.result), 32'd0);
      check("rst_flags", {29'd0, bus.carryout, bus.overflow, bus.zero}, 32'd0);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("rst_nodone", 32'(bus.done), 32'd0);
      end
      run_lit("post_rst", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0);

      // randomized ops with junk starts during RUN and occasional back-to-back issue
      b2b = 0;
      for (int k = 0; k < 40; k++) begin
         int junk;
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom_range(1));
         if (k % 10 == 0) rb = ra;
         if (b2b) drive_start(ra, rb, rs);
         else     start_op(ra, rb, rs);
         junk = $urandom_range(3);
         for (int j = 0; j < junk; j++) drive_start(W'($urandom), W'($urandom), 1'($urandom_range(1)));
         wait_done(1 + junk, cyc);
         check("rnd_lat", 32'(cyc), 32'(W + 1));
         b2b = ($urandom_range(1) == 1);
      end
      @(negedge clk);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
